// File: rtl/mdu_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_iter
// Purpose  : Iterative restoring divider for DIV/DIVU (LO=quotient, HI=remainder).
// Revision : 1.0 - initial release
// ============================================================================
module mdu_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             is_signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvsr_q;
   logic [CW-1:0]    cnt_q;
   logic             q_neg_q;
   logic             r_neg_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;

   logic [WIDTH-1:0] abs_a_d;
   logic [WIDTH-1:0] abs_b_d;
   logic [WIDTH:0]   rem_sh_d;
   logic [WIDTH:0]   trial_d;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;

   always_comb begin
      abs_a_d  = (is_signed_i && dividend_i[WIDTH-1]) ? (~dividend_i + 1'b1) : dividend_i;
      abs_b_d  = (is_signed_i && divisor_i[WIDTH-1])  ? (~divisor_i + 1'b1)  : divisor_i;
      // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
      rem_sh_d = {rem_q, quo_q[WIDTH-1]};
      trial_d  = rem_sh_d - {1'b0, dvsr_q};
      if (!trial_d[WIDTH]) begin
         rem_d = trial_d[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_d = rem_sh_d[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         cnt_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  rem_q   <= '0;
                  quo_q   <= abs_a_d;
                  dvsr_q  <= abs_b_d;
                  cnt_q   <= '0;
                  q_neg_q <= is_signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                  r_neg_q <= is_signed_i & dividend_i[WIDTH-1];
                  if (divisor_i == '0) begin
                     // Divide by zero: fixed all-ones quotient, raw dividend as remainder
                     quotient_q  <= '1;
                     remainder_q <= dividend_i;
                     state_q     <= DONE;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  quotient_q  <= q_neg_q ? (~quo_d + 1'b1) : quo_d;
                  remainder_q <= r_neg_q ? (~rem_d + 1'b1) : rem_d;
                  state_q     <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;

endmodule
`default_nettype wire
